// File: rtl/uart_pkg.sv
// Shared constants for the buffered UART: register map, status bit positions and TX FSM states.
package uart_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'd0;
  localparam logic [3:0] ADDR_COUNT  = 4'd1;
  localparam logic [3:0] ADDR_STATUS = 4'd2;
  localparam logic [3:0] ADDR_CTRL   = 4'd3;
  localparam logic [3:0] ADDR_IRQ    = 4'd4;

  localparam int STAT_TX_BUSY     = 0;
  localparam int STAT_TX_OVERFLOW = 1;
  localparam int STAT_RX_OVERRUN  = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_BUSY} tx_state_t;

  // FIFO occupancy can reach 128 but the register field is only 7 bits wide
  function automatic logic [6:0] sat7(input logic [7:0] n);
    return (n > 8'd127) ? 7'd127 : n[6:0];
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receive deserializer; valid pulses for one cycle in mid stop bit on a good frame.
module uart_rx #(
  parameter int CLKFREQ = 50000000,
  parameter int BAUD    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);

  localparam int DIV = CLKFREQ / BAUD;

  logic [1:0]  sync;
  logic        busy;
  logic [3:0]  bit_idx;
  logic [19:0] cnt;

  // The first wait is shortened by the synchroniser latency to land mid-bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      busy    <= 1'b0;
      bit_idx <= 4'd0;
      cnt     <= '0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      sync  <= {sync[0], rx};
      valid <= 1'b0;
      if (!busy) begin
        if (!sync[1]) begin
          busy    <= 1'b1;
          bit_idx <= 4'd0;
          cnt     <= 20'(DIV / 2 - 1);
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt     <= 20'(DIV - 1);
        bit_idx <= bit_idx + 1'b1;
        if (bit_idx == 4'd0) begin
          if (sync[1]) busy <= 1'b0;
        end else if (bit_idx <= 4'd8) begin
          data <= {sync[1], data[7:1]};
        end else begin
          busy  <= 1'b0;
          valid <= sync[1];
        end
      end
    end
  end

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with flush; a pop frees room for a same-cycle push when full.
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = count[DEPTH_LOG2];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmit serializer; ready is high whenever no frame is in flight.
module uart_tx #(
  parameter int CLKFREQ = 50000000,
  parameter int BAUD    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int DIV = CLKFREQ / BAUD;

  logic [8:0]  shift;
  logic [3:0]  bits_left;
  logic [19:0] cnt;

  assign ready = (bits_left == 4'd0);

  // The shifter fills with ones, so the stop bit and idle level fall out naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      shift     <= '1;
      bits_left <= 4'd0;
      cnt       <= '0;
      tx        <= 1'b1;
    end else if (ready) begin
      if (start) begin
        shift     <= {1'b1, data};
        bits_left <= 4'd10;
        cnt       <= 20'(DIV - 1);
        tx        <= 1'b0;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      cnt       <= 20'(DIV - 1);
      bits_left <= bits_left - 1'b1;
      tx        <= shift[0];
      shift     <= {1'b1, shift[8:1]};
    end
  end

endmodule

// File: rtl/uart_buffered.sv
// Bus-mapped UART with TX/RX FIFOs; define UART_BUFFERED_IRQ_EN to add the irq output and enable register.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int CLKFREQ       = 50000000,
  parameter int BAUD          = 9600,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  input  logic        select,
  input  logic        write,
  input  logic [3:0]  address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out
`ifdef UART_BUFFERED_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic sel_d, first, wr_en, rd_pending;
  logic rx_pop, rx_flush, rx_full, rx_empty, rx_valid, rx_overrun;
  logic tx_push, tx_pop, tx_flush, tx_full, tx_empty, tx_overflow, tx_busy;
  logic ser_start, ser_ready, seen_low;
  logic [7:0] rx_dout, rx_byte, rx_head, tx_head, tx_byte;
  logic [RX_DEPTH_LOG2:0] rx_count;
  logic [TX_DEPTH_LOG2:0] tx_count;
  tx_state_t state, state_nx;
  logic unused_bits;

  assign unused_bits = ^data_in[15:8];
  assign first    = select && !sel_d;
  assign wr_en    = first && write;
  assign tx_push  = wr_en && (address == ADDR_DATA);
  assign tx_flush = wr_en && (address == ADDR_CTRL) && data_in[1];
  assign rx_flush = wr_en && (address == ADDR_CTRL) && data_in[0];
  assign rx_pop   = rd_pending && !select;
  assign rx_head  = rx_empty ? 8'h00 : rx_dout;
  assign tx_busy  = !tx_empty || (state != TX_IDLE);

  uart_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_valid), .pop(rx_pop), .flush(rx_flush),
    .din(rx_byte), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(data_in[7:0]), .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_tx #(.CLKFREQ(CLKFREQ), .BAUD(BAUD)) u_tx (
    .clk(clk), .rst(rst), .start(ser_start), .data(tx_byte), .tx(tx), .ready(ser_ready)
  );

  uart_rx #(.CLKFREQ(CLKFREQ), .BAUD(BAUD)) u_rx (
    .clk(clk), .rst(rst), .rx(rx), .data(rx_byte), .valid(rx_valid)
  );

  // A read of the data register is remembered so the pop happens once select drops
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_d       <= 1'b0;
      rd_pending  <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      sel_d <= select;
      if (first && !write && (address == ADDR_DATA) && !rx_empty) rd_pending <= 1'b1;
      else if (!select)                                           rd_pending <= 1'b0;
      if (rx_valid && rx_full && !rx_pop && !rx_flush)                   rx_overrun <= 1'b1;
      else if (wr_en && (address == ADDR_STATUS) && data_in[2])         rx_overrun <= 1'b0;
      if (tx_push && tx_full && !tx_pop)                                 tx_overflow <= 1'b1;
      else if (wr_en && (address == ADDR_STATUS) && data_in[1])         tx_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TX_IDLE;
      seen_low <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      state <= state_nx;
      if (tx_pop) tx_byte <= tx_head;
      if (state != TX_BUSY) seen_low <= 1'b0;
      else if (!ser_ready)  seen_low <= 1'b1;
    end
  end

  // A flush in the same cycle suppresses launching the head byte it is discarding
  always_comb begin
    state_nx  = state;
    tx_pop    = 1'b0;
    ser_start = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!tx_empty && ser_ready && !tx_flush) begin
          state_nx = TX_START;
          tx_pop   = 1'b1;
        end
      end
      TX_START: begin
        ser_start = 1'b1;
        state_nx  = TX_BUSY;
      end
      TX_BUSY: if (seen_low && ser_ready) state_nx = TX_IDLE;
      default: state_nx = TX_IDLE;
    endcase
  end

`ifdef UART_BUFFERED_IRQ_EN
  logic [1:0] irq_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 2'b00;
      irq    <= 1'b0;
    end else begin
      if (wr_en && (address == ADDR_IRQ)) irq_en <= data_in[1:0];
      irq <= (irq_en[0] && !rx_empty) || (irq_en[1] && !tx_busy) || rx_overrun;
    end
  end
`endif

  always_comb begin
    data_out = 16'h0000;
    if (select && !write && !rst) begin
      case (address)
        ADDR_DATA:   data_out = {!rx_empty, !tx_full, 6'b0, rx_head};
        ADDR_COUNT:  data_out = {1'b0, sat7(8'(tx_count)), 1'b0, sat7(8'(rx_count))};
        ADDR_STATUS: begin
          data_out[STAT_TX_BUSY]     = tx_busy;
          data_out[STAT_TX_OVERFLOW] = tx_overflow;
          data_out[STAT_RX_OVERRUN]  = rx_overrun;
        end
`ifdef UART_BUFFERED_IRQ_EN
        ADDR_IRQ:    data_out = {14'b0, irq_en};
`endif
        default:     data_out = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_buffered.sv
// Directed bench for uart_buffered: register table at reset, then serial TX/RX, overflow, hold and reset sequences.
module tb_uart_buffered;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD_R = 100_000;
  localparam int DIV    = CLK_HZ / BAUD_R;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx1 = 1'b1;
  logic        rx2 = 1'b1;
  logic        tx1, tx2;
  logic        sel1 = 1'b0;
  logic        sel2 = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [15:0] din = 16'h0000;
  logic [15:0] dout1, dout2;
`ifdef UART_BUFFERED_IRQ_EN
  logic        irq1, irq2;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] rd_first;
  logic        rd_stable;
  logic [7:0]  tx_q[$];

  typedef struct {
    logic        write;
    logic [3:0]  address;
    logic [15:0] data_in;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  uart_buffered #(.CLKFREQ(CLK_HZ), .BAUD(BAUD_R), .TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .rx(rx1), .tx(tx1), .select(sel1), .write(wr),
    .address(addr), .data_in(din), .data_out(dout1)
`ifdef UART_BUFFERED_IRQ_EN
    , .irq(irq1)
`endif
  );

  uart_buffered #(.CLKFREQ(CLK_HZ), .BAUD(BAUD_R), .TX_DEPTH_LOG2(2), .RX_DEPTH_LOG2(1)) dut2 (
    .clk(clk), .rst(rst), .rx(rx2), .tx(tx2), .select(sel2), .write(wr),
    .address(addr), .data_in(din), .data_out(dout2)
`ifdef UART_BUFFERED_IRQ_EN
    , .irq(irq2)
`endif
  );

  // Decodes every frame on the first instance's tx line into tx_q
  initial begin
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(negedge tx1);
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = tx1;
      end
      repeat (DIV) @(negedge clk);
      tx_q.push_back(b);
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One access of ncyc cycles; first sample kept in rd_first, rd_stable clears if data_out moves
  task automatic applyStimulus(input int which, input logic w, input logic [3:0] a,
                               input logic [15:0] d, input int ncyc);
    @(negedge clk);
    wr = w; addr = a; din = d;
    if (which == 0) sel1 = 1'b1; else sel2 = 1'b1;
    #1;
    rd_first  = (which == 0) ? dout1 : dout2;
    rd_stable = 1'b1;
    for (int i = 1; i < ncyc; i++) begin
      @(negedge clk);
      #1;
      if (((which == 0) ? dout1 : dout2) !== rd_first) rd_stable = 1'b0;
    end
    @(negedge clk);
    sel1 = 1'b0; sel2 = 1'b0; wr = 1'b0;
  endtask

  task automatic sendByte(input int which, input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (which == 0) rx1 = frame[i]; else rx2 = frame[i];
      repeat (DIV - 1) @(negedge clk);
    end
  endtask

  task automatic waitTxBytes(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (tx_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("tx_frames_seen", 16'(tx_q.size()), 16'(n));
  endtask

  initial begin
    int q0;

    vecs[0]  = '{1'b0, 4'd0,  16'h0000, 16'h4000};
    vecs[1]  = '{1'b0, 4'd1,  16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 4'd2,  16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 4'd3,  16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 4'd4,  16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 4'd15, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b1, 4'd4,  16'h0001, 16'h0000};
`ifdef UART_BUFFERED_IRQ_EN
    vecs[7]  = '{1'b0, 4'd4,  16'h0000, 16'h0001};
`else
    vecs[7]  = '{1'b0, 4'd4,  16'h0000, 16'h0000};
`endif
    vecs[8]  = '{1'b1, 4'd4,  16'h0000, 16'h0000};
    vecs[9]  = '{1'b1, 4'd2,  16'hFFFF, 16'h0000};
    vecs[10] = '{1'b0, 4'd2,  16'h0000, 16'h0000};
    vecs[11] = '{1'b1, 4'd9,  16'h00AB, 16'h0000};
    vecs[12] = '{1'b0, 4'd1,  16'h0000, 16'h0000};

    repeat (3) @(negedge clk);
    checkOutput("reset_tx_line", 16'(tx1), 16'h0001);
    rst = 1'b0;
`ifdef UART_BUFFERED_IRQ_EN
    checkOutput("reset_irq", 16'(irq1), 16'h0000);
`endif

    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, vecs[i].write, vecs[i].address, vecs[i].data_in, 1);
      checkOutput($sformatf("vec%0d", i), rd_first, vecs[i].expected);
    end

    // Back-to-back writes: start bit must appear exactly two cycles after the write
    applyStimulus(0, 1'b1, 4'd0, 16'h0041, 1);
    @(negedge clk);
    checkOutput("tx_high_before_start", 16'(tx1), 16'h0001);
    @(negedge clk);
    checkOutput("tx_start_bit_timing", 16'(tx1), 16'h0000);
    applyStimulus(0, 1'b1, 4'd0, 16'h0042, 1);
    applyStimulus(0, 1'b1, 4'd0, 16'h0043, 1);
    waitTxBytes(3, 12 * 10 * DIV);
    checkOutput("tx_byte0", 16'(tx_q[0]), 16'h0041);
    checkOutput("tx_byte1", 16'(tx_q[1]), 16'h0042);
    checkOutput("tx_byte2", 16'(tx_q[2]), 16'h0043);

    // Receive two bytes and read them out in order
    sendByte(0, 8'h55);
    sendByte(0, 8'hAA);
    repeat (4) @(negedge clk);
    checkOutput("dout_idle_zero", dout1, 16'h0000);
    applyStimulus(0, 1'b0, 4'd0, 16'h0000, 1);
    checkOutput("rx_read_55", rd_first, 16'hC055);
    applyStimulus(0, 1'b0, 4'd0, 16'h0000, 1);
    checkOutput("rx_read_AA", rd_first, 16'hC0AA);
    applyStimulus(0, 1'b0, 4'd0, 16'h0000, 1);
    checkOutput("rx_read_empty", rd_first, 16'h4000);

    // Held select: one pop per read access, one push per write access
    sendByte(0, 8'h11);
    sendByte(0, 8'h22);
    repeat (4) @(negedge clk);
    applyStimulus(0, 1'b0, 4'd0, 16'h0000, 5);
    checkOutput("hold_read_data", rd_first, 16'hC011);
    checkOutput("hold_read_stable", 16'(rd_stable), 16'h0001);
    applyStimulus(0, 1'b0, 4'd1, 16'h0000, 1);
    checkOutput("hold_read_one_pop", rd_first, 16'h0001);
    applyStimulus(0, 1'b0, 4'd0, 16'h0000, 1);
    checkOutput("hold_read_next", rd_first, 16'hC022);
    q0 = tx_q.size();
    applyStimulus(0, 1'b1, 4'd0, 16'h005A, 5);
    repeat (3 * 10 * DIV) @(negedge clk);
    checkOutput("hold_write_one_push", 16'(tx_q.size()), 16'(q0 + 1));
    checkOutput("hold_write_byte", 16'(tx_q[tx_q.size() - 1]), 16'h005A);

    // RX flush through the control register
    sendByte(0, 8'h33);
    repeat (4) @(negedge clk);
    applyStimulus(0, 1'b0, 4'd1, 16'h0000, 1);
    checkOutput("pre_flush_count", rd_first, 16'h0001);
    applyStimulus(0, 1'b1, 4'd3, 16'h0001, 1);
    applyStimulus(0, 1'b0, 4'd1, 16'h0000, 1);
    checkOutput("post_flush_count", rd_first, 16'h0000);

    // Small TX FIFO overflow while the serializer is busy
    applyStimulus(1, 1'b1, 4'd0, 16'h00F0, 1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1'b1, 4'd0, 16'(16'h0060 + i), 1);
    applyStimulus(1, 1'b0, 4'd1, 16'h0000, 1);
    checkOutput("ovf_tx_count", rd_first, 16'h0400);
    applyStimulus(1, 1'b0, 4'd0, 16'h0000, 1);
    checkOutput("ovf_tx_full_flag", rd_first, 16'h0000);
    applyStimulus(1, 1'b0, 4'd2, 16'h0000, 1);
    checkOutput("ovf_status", rd_first, 16'h0003);
    applyStimulus(1, 1'b1, 4'd2, 16'h0002, 1);
    applyStimulus(1, 1'b0, 4'd2, 16'h0000, 1);
    checkOutput("ovf_cleared", rd_first, 16'h0001);

    // Small RX FIFO overrun: third byte is lost
    sendByte(1, 8'h01);
    sendByte(1, 8'h02);
    sendByte(1, 8'h03);
    repeat (4) @(negedge clk);
    applyStimulus(1, 1'b0, 4'd1, 16'h0000, 1);
    checkOutput("ovr_rx_count", 16'(rd_first[7:0]), 16'h0002);
    applyStimulus(1, 1'b0, 4'd2, 16'h0000, 1);
    checkOutput("ovr_flag", 16'(rd_first[2]), 16'h0001);
    applyStimulus(1, 1'b0, 4'd0, 16'h0000, 1);
    checkOutput("ovr_byte0", {7'd0, rd_first[15], rd_first[7:0]}, 16'h0101);
    applyStimulus(1, 1'b0, 4'd0, 16'h0000, 1);
    checkOutput("ovr_byte1", {7'd0, rd_first[15], rd_first[7:0]}, 16'h0102);
    applyStimulus(1, 1'b0, 4'd0, 16'h0000, 1);
    checkOutput("ovr_third_lost", 16'(rd_first[15]), 16'h0000);

`ifdef UART_BUFFERED_IRQ_EN
    applyStimulus(0, 1'b1, 4'd4, 16'h0001, 1);
    sendByte(0, 8'h10);
    repeat (4) @(negedge clk);
    checkOutput("irq_rx_avail", 16'(irq1), 16'h0001);
    applyStimulus(0, 1'b0, 4'd0, 16'h0000, 1);
    checkOutput("irq_read_data", rd_first, 16'hC010);
    @(negedge clk);
    @(negedge clk);
    checkOutput("irq_cleared_after_pop", 16'(irq1), 16'h0000);
`endif

    // Reset in the middle of a frame with bytes still queued
    applyStimulus(0, 1'b1, 4'd0, 16'h0081, 1);
    applyStimulus(0, 1'b1, 4'd0, 16'h0082, 1);
    applyStimulus(0, 1'b1, 4'd0, 16'h0083, 1);
    repeat (2 * DIV) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midframe_rst_tx", 16'(tx1), 16'h0001);
    rst = 1'b0;
    applyStimulus(0, 1'b0, 4'd1, 16'h0000, 1);
    checkOutput("midframe_rst_counts", rd_first, 16'h0000);
    applyStimulus(0, 1'b0, 4'd2, 16'h0000, 1);
    checkOutput("midframe_rst_status", rd_first, 16'h0000);
`ifdef UART_BUFFERED_IRQ_EN
    checkOutput("midframe_rst_irq", 16'(irq1), 16'h0000);
`endif
    repeat (2 * DIV) @(negedge clk);
    checkOutput("midframe_rst_line_idle", 16'(tx1), 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
